pipeline_debug_ctrl: RTL and testbench

PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

---
 rtl/pipeline_debug_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_ctrl.sv
// UART-driven debug controller: gates the core clock enable for run and single-step,
// snapshots the pipeline latches and streams them MSB-first. Optional macro BREAKPOINT_EN adds a PC breakpoint.
module pipeline_debug_ctrl #(
    parameter int DBG_W  = 322,
    parameter int PC_W   = 10,
    parameter int NBYTES = (DBG_W + 7) / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DBG_W-1:0]  debug_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              halt_in,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rd,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              wr,
    output logic              cpu_enable,
    output logic              halted
);

    localparam int SNAP_W = 8 * NBYTES;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_STEP    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_BP_HI   = 3'd5;
    localparam logic [2:0] ST_BP_LO   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              rd_q, rd_d;
    logic              dec_q, dec_d;
    logic              halted_q, halted_d;
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cpu_en_s;
    logic              wr_s;
    logic              bp_hit_s;

`ifdef BREAKPOINT_EN
    logic [PC_W-1:0]   bp_q, bp_d;
    logic              bp_valid_q, bp_valid_d;
    logic [7:0]        bp_hi_q, bp_hi_d;

    // Combinational so the enable drops in the very cycle the breakpoint PC appears
    assign bp_hit_s = bp_valid_q && (pc_in == bp_q);
`else
    logic              unused_pc_s;

    assign unused_pc_s = ^pc_in;
    assign bp_hit_s    = 1'b0;
`endif

    // Next-state, FIFO handshakes, snapshot load/shift and clock-enable gating
    always_comb begin
        state_d  = state_q;
        rd_d     = 1'b0;
        dec_d    = rd_q;
        snap_d   = snap_q;
        cnt_d    = cnt_q;
        cpu_en_s = 1'b0;
        wr_s     = 1'b0;
`ifdef BREAKPOINT_EN
        bp_d       = bp_q;
        bp_valid_d = bp_valid_q;
        bp_hi_d    = bp_hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dec_q) begin
                    case (rx_data)
                        8'h63:   state_d = ST_RUN;
                        8'h73:   state_d = ST_STEP;
                        8'h64:   state_d = ST_CAPTURE;
`ifdef BREAKPOINT_EN
                        8'h62:   state_d = ST_BP_HI;
`endif
                        default: state_d = ST_IDLE;
                    endcase
                end else if (!rx_empty && !rd_q) begin
                    rd_d = 1'b1;
                end else begin
                    rd_d = 1'b0;
                end
            end
            ST_RUN: begin
                cpu_en_s = !bp_hit_s;
                if (halt_in || !rx_empty || bp_hit_s) begin
                    state_d = ST_CAPTURE;
                    rd_d    = !rx_empty;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                cpu_en_s = 1'b1;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                snap_d  = SNAP_W'(debug_in);
                cnt_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_full) begin
                    wr_s   = 1'b1;
                    snap_d = {snap_q[SNAP_W-9:0], 8'h00};
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    wr_s = 1'b0;
                end
            end
`ifdef BREAKPOINT_EN
            ST_BP_HI: begin
                if (dec_q) begin
                    bp_hi_d = rx_data;
                    state_d = ST_BP_LO;
                end else if (!rx_empty && !rd_q) begin
                    rd_d = 1'b1;
                end else begin
                    rd_d = 1'b0;
                end
            end
            ST_BP_LO: begin
                if (dec_q) begin
                    bp_d       = PC_W'({bp_hi_q, rx_data});
                    bp_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (!rx_empty && !rd_q) begin
                    rd_d = 1'b1;
                end else begin
                    rd_d = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        halted_d = (state_d == ST_IDLE);
    end

    // State and handshake registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rd_q     <= 1'b0;
            dec_q    <= 1'b0;
            halted_q <= 1'b1;
            snap_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            dec_q    <= dec_d;
            halted_q <= halted_d;
            snap_q   <= snap_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef BREAKPOINT_EN
    // Breakpoint registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bp_q       <= '1;
            bp_valid_q <= 1'b0;
            bp_hi_q    <= 8'h00;
        end else begin
            bp_q       <= bp_d;
            bp_valid_q <= bp_valid_d;
            bp_hi_q    <= bp_hi_d;
        end
    end
`endif

    // wr follows tx_full within the cycle so a full FIFO never sees a push
    assign rd         = rd_q;
    assign wr         = wr_s;
    assign tx_data    = wr_s ? snap_q[SNAP_W-1 -: 8] : 8'h00;
    assign cpu_enable = cpu_en_s;
    assign halted     = halted_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: step, run/halt, backpressure, reset mid-dump,
// unknown commands, RUN stop by received byte, and breakpoint (BREAKPOINT_EN) or its absence.
module tb_pipeline_debug_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic [321:0] debug_in;
    logic [9:0]   pc_in = 10'd0;
    logic         halt_in;
    logic [7:0]   rx_data;
    logic         rx_empty;
    logic         rd;
    logic         tx_full;
    logic [7:0]   tx_data;
    logic         wr;
    logic         cpu_enable;
    logic         halted;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q[$];
    int         en_cnt   = 0;
    int         viol     = 0;
    logic       rd_prev  = 1'b0;
    logic       pc_clr   = 1'b1;
    logic       en_at7   = 1'b0;

    pipeline_debug_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .debug_in   (debug_in),
        .pc_in      (pc_in),
        .halt_in    (halt_in),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .rd         (rd),
        .tx_full    (tx_full),
        .tx_data    (tx_data),
        .wr         (wr),
        .cpu_enable (cpu_enable),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    // Mock core: PC advances only on enabled cycles
    always @(posedge clock) begin
        if (pc_clr) pc_in <= 10'd0;
        else if (cpu_enable) pc_in <= pc_in + 10'd1;
    end

    // Observe transmitted bytes, enable cycles and handshake overlaps
    always @(negedge clock) begin
        if (wr) q.push_back(tx_data);
        if (cpu_enable) en_cnt++;
        if (rd && wr) viol++;
        if (rd && rd_prev) viol++;
        rd_prev = rd;
        if (!pc_clr && pc_in == 10'd7 && cpu_enable) en_at7 = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Padded snapshot: top byte is 0x02, remaining bytes are base+39 down to base+0
    function automatic logic [321:0] make_dbg(input logic [7:0] base);
        logic [321:0] d;
        d = '0;
        for (int j = 0; j < 40; j++) d[8*j +: 8] = base + 8'(j);
        d[321:320] = 2'b10;
        return d;
    endfunction

    task automatic check_dump(input string tag, input logic [7:0] base);
        int         errs;
        logic [7:0] e;
        errs = 0;
        check_eq({tag, "_len"}, 64'(q.size()), 64'd41);
        for (int i = 0; i < q.size() && i < 41; i++) begin
            e = (i == 0) ? 8'h02 : base + 8'(40 - i);
            if (q[i] !== e) errs++;
        end
        check_eq({tag, "_bytes"}, 64'(errs), 64'd0);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_empty = 1'b0;
        do begin
            @(negedge clock); #1;
            n++;
        end while (rd !== 1'b1 && n < 20);
        rx_empty = 1'b0;
        if (rd !== 1'b1) check_eq("rd_timeout", 64'(rd), 64'd1);
        rx_empty = 1'b1;
        repeat (2) begin
            @(negedge clock); #1;
        end
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int n;
        n = 0;
        while (q.size() < target && n < budget) begin
            @(negedge clock); #1;
            n++;
        end
        if (q.size() < target) check_eq("byte_timeout", 64'(q.size()), 64'(target));
        repeat (3) begin
            @(negedge clock); #1;
        end
    endtask

    task automatic wait_enable();
        int n;
        n = 0;
        while (cpu_enable !== 1'b1 && en_cnt == 0 && n < 20) begin
            @(negedge clock); #1;
            n++;
        end
        if (en_cnt == 0) check_eq("run_start_timeout", 64'(en_cnt), 64'd1);
    endtask

    task automatic wait_en_cnt(input int target);
        int n;
        n = 0;
        while (en_cnt < target && n < 200) begin
            @(negedge clock); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        tx_full  = 1'b0;
        halt_in  = 1'b0;
        debug_in = make_dbg(8'h20);
        repeat (2) begin
            @(negedge clock); #1;
        end
        check_eq("rst_halted", 64'(halted), 64'd1);
        check_eq("rst_cpu_en", 64'(cpu_enable), 64'd0);
        check_eq("rst_rd", 64'(rd), 64'd0);
        check_eq("rst_wr", 64'(wr), 64'd0);
        check_eq("rst_tx_data", 64'(tx_data), 64'h00);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock); #1;
        end

        // Single step
        q.delete(); en_cnt = 0;
        send_cmd(8'h73);
        wait_bytes(41, 200);
        check_eq("step_en_cycles", 64'(en_cnt), 64'd1);
        check_dump("step", 8'h20);
        check_eq("step_first_byte", 64'(q.size() > 0 ? q[0] : 8'hxx), 64'h02);
        check_eq("step_halted", 64'(halted), 64'd1);

        // Run, halt after 20 enabled cycles; snapshot must be the CAPTURE-cycle value
        debug_in = make_dbg(8'h40);
        q.delete(); en_cnt = 0;
        send_cmd(8'h63);
        wait_enable();
        wait_en_cnt(20);
        halt_in  = 1'b1;
        debug_in = make_dbg(8'h10);
        @(negedge clock); #1;
        check_eq("run_capture_en", 64'(cpu_enable), 64'd0);
        debug_in = make_dbg(8'h30);
        halt_in  = 1'b0;
        @(negedge clock); #1;
        debug_in = make_dbg(8'h60);
        wait_bytes(41, 200);
        check_eq("run_en_cycles", 64'(en_cnt), 64'd20);
        check_dump("run_halt", 8'h30);

        // Backpressure at byte 10
        debug_in = make_dbg(8'h50);
        q.delete();
        send_cmd(8'h64);
        n = 0;
        while (q.size() < 10 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        tx_full = 1'b1;
        repeat (5) begin
            @(posedge clock); #1;
        end
        check_eq("txfull_hold", 64'(q.size()), 64'd10);
        tx_full = 1'b0;
        wait_bytes(41, 200);
        check_dump("txfull", 8'h50);

        // Reset in the middle of a dump
        debug_in = make_dbg(8'h70);
        q.delete();
        send_cmd(8'h64);
        n = 0;
        while (q.size() < 20 && n < 100) begin
            @(negedge clock); #1;
            n++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock); #1;
        end
        reset = 1'b1;
        repeat (50) begin
            @(negedge clock); #1;
        end
        check_eq("rst_mid_no_wr", 64'(q.size()), 64'd20);
        check_eq("rst_mid_halted", 64'(halted), 64'd1);
        check_eq("rst_mid_cpu_en", 64'(cpu_enable), 64'd0);
        q.delete(); en_cnt = 0;
        send_cmd(8'h64);
        wait_bytes(41, 200);
        check_dump("rst_redump", 8'h70);
        check_eq("rst_redump_en", 64'(en_cnt), 64'd0);

        // Unknown byte ignored, then a plain dump
        q.delete(); en_cnt = 0;
        send_cmd(8'h41);
        repeat (10) begin
            @(negedge clock); #1;
        end
        check_eq("unk_no_wr", 64'(q.size()), 64'd0);
        check_eq("unk_no_en", 64'(en_cnt), 64'd0);
        check_eq("unk_halted", 64'(halted), 64'd1);
        send_cmd(8'h64);
        wait_bytes(41, 200);
        check_dump("unk_dump", 8'h70);
        check_eq("unk_dump_en", 64'(en_cnt), 64'd0);

        // RUN stopped by a received byte after 5 enabled cycles
        debug_in = make_dbg(8'h05);
        q.delete(); en_cnt = 0;
        send_cmd(8'h63);
        wait_enable();
        wait_en_cnt(5);
        rx_data  = 8'h55;
        rx_empty = 1'b0;
        n = 0;
        while (rd !== 1'b1 && n < 20) begin
            @(negedge clock); #1;
            n++;
        end
        rx_empty = 1'b1;
        wait_bytes(41, 200);
        check_eq("rxstop_en_cycles", 64'(en_cnt), 64'd5);
        check_dump("rxstop", 8'h05);

`ifdef BREAKPOINT_EN
        // Breakpoint at PC 7
        send_cmd(8'h62);
        send_cmd(8'h00);
        send_cmd(8'h07);
        repeat (3) begin
            @(negedge clock); #1;
        end
        check_eq("bp_setup_halted", 64'(halted), 64'd1);
        debug_in = make_dbg(8'h33);
        q.delete(); en_cnt = 0; en_at7 = 1'b0;
        pc_clr = 1'b0;
        send_cmd(8'h63);
        wait_bytes(41, 300);
        check_eq("bp_en_cycles", 64'(en_cnt), 64'd7);
        check_eq("bp_pc_stop", 64'(pc_in), 64'd7);
        check_eq("bp_en_at_pc7", 64'(en_at7), 64'd0);
        check_dump("bp", 8'h33);
`else
        // 'b' is an unknown command in this build
        q.delete(); en_cnt = 0;
        send_cmd(8'h62);
        repeat (10) begin
            @(negedge clock); #1;
        end
        check_eq("nobp_no_wr", 64'(q.size()), 64'd0);
        check_eq("nobp_no_en", 64'(en_cnt), 64'd0);
        check_eq("nobp_halted", 64'(halted), 64'd1);
`endif

        check_eq("rd_wr_overlap", 64'(viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
